// File: rtl/y86_pipe_regs_pkg.sv
// Y86-64 pipeline register bank: shared constants,
// width helpers, field offsets and bubble images.
package y86_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int ICODE_W = 4;
  localparam int IFUN_W  = 4;

  function automatic int d_w(
    input int stat_w,
    input int word_w
  );
    return stat_w + 16 + 2 * word_w;
  endfunction

  function automatic int e_w(
    input int stat_w,
    input int word_w,
    input int regid_w
  );
    return stat_w + 8 + 3 * word_w
         + 4 * regid_w;
  endfunction

  function automatic int m_w(
    input int stat_w,
    input int word_w,
    input int regid_w
  );
    return stat_w + 5 + 2 * word_w
         + 2 * regid_w;
  endfunction

  function automatic int w_w(
    input int stat_w,
    input int word_w,
    input int regid_w
  );
    return stat_w + 4 + 2 * word_w
         + 2 * regid_w;
  endfunction

  // LSB of the icode field in any image:
  // icode always sits directly below stat.
  function automatic int icode_lsb(
    input int img_w,
    input int stat_w
  );
    return img_w - stat_w - ICODE_W;
  endfunction

  // Default-configuration widths.
  localparam int DEF_D_W = d_w(3, 64);
  localparam int DEF_E_W = e_w(3, 64, 4);
  localparam int DEF_M_W = m_w(3, 64, 4);
  localparam int DEF_W_W = w_w(3, 64, 4);

  // Default-configuration field offsets (LSB).
  localparam int D_VALP_LSB  = 0;
  localparam int D_VALC_LSB  = 64;
  localparam int D_ICODE_LSB = icode_lsb(DEF_D_W, 3);
  localparam int E_SRCB_LSB  = 0;
  localparam int E_SRCA_LSB  = 4;
  localparam int E_DSTM_LSB  = 8;
  localparam int E_DSTE_LSB  = 12;
  localparam int E_ICODE_LSB = icode_lsb(DEF_E_W, 3);
  localparam int M_ICODE_LSB = icode_lsb(DEF_M_W, 3);
  localparam int W_ICODE_LSB = icode_lsb(DEF_W_W, 3);

  // Default-configuration bubble images.
  localparam logic [DEF_D_W-1:0] D_BUBBLE_DEF =
    {SAOK, INOP, 4'h0, RNONE, RNONE, 128'd0};
  localparam logic [DEF_E_W-1:0] E_BUBBLE_DEF =
    {SAOK, INOP, 4'h0, 192'd0,
     RNONE, RNONE, RNONE, RNONE};
  localparam logic [DEF_M_W-1:0] M_BUBBLE_DEF =
    {SAOK, INOP, 1'b0, 128'd0, RNONE, RNONE};
  localparam logic [DEF_W_W-1:0] W_BUBBLE_DEF =
    {SAOK, INOP, 128'd0, RNONE, RNONE};

endpackage

// File: rtl/y86_pipe_regs_stage.sv
// Generic pipeline register with
// rst > stall > bubble > load priority.
module pipe_stage_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter bit               RST_VALID  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_bubble,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  // Stage contents and valid flag; stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= BUBBLE_VAL;
      r_valid <= RST_VALID;
    end else if (i_stall) begin
      r_q     <= r_q;
      r_valid <= r_valid;
    end else if (i_bubble) begin
      r_q     <= BUBBLE_VAL;
      r_valid <= 1'b0;
    end else begin
      r_q     <= i_d;
      r_valid <= 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/y86_pipe_regs.sv
// Y86-64 F/D/E/M/W pipeline register bank with
// sticky control-conflict flag and retire counter.
module y86_pipe_regs
  import y86_pkg::*;
#(
  parameter int                WORD_W   = 64,
  parameter int                REGID_W  = 4,
  parameter int                STAT_W   = 3,
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32,
  localparam int D_W = d_w(STAT_W, WORD_W),
  localparam int E_W = e_w(STAT_W, WORD_W, REGID_W),
  localparam int M_W = m_w(STAT_W, WORD_W, REGID_W),
  localparam int W_W = w_w(STAT_W, WORD_W, REGID_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] f_next,
  input  logic [D_W-1:0]    d_next,
  input  logic [E_W-1:0]    e_next,
  input  logic [M_W-1:0]    m_next,
  input  logic [W_W-1:0]    w_next,
  input  logic [4:0]        stall,
  input  logic [4:0]        bubble,
  output logic [WORD_W-1:0] F_q,
  output logic [D_W-1:0]    D_q,
  output logic [E_W-1:0]    E_q,
  output logic [M_W-1:0]    M_q,
  output logic [W_W-1:0]    W_q,
  output logic [4:0]        valid,
  output logic              ctrl_err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [STAT_W-1:0] S_OK =
    STAT_W'(SAOK);
  localparam logic [REGID_W-1:0] R_NONE =
    REGID_W'(RNONE);

  localparam logic [D_W-1:0] D_BUB = {
    S_OK, INOP, 4'h0, RNONE, RNONE,
    {(2*WORD_W){1'b0}}
  };
  localparam logic [E_W-1:0] E_BUB = {
    S_OK, INOP, 4'h0,
    {(3*WORD_W){1'b0}}, {4{R_NONE}}
  };
  localparam logic [M_W-1:0] M_BUB = {
    S_OK, INOP, 1'b0,
    {(2*WORD_W){1'b0}}, {2{R_NONE}}
  };
  localparam logic [W_W-1:0] W_BUB = {
    S_OK, INOP,
    {(2*WORD_W){1'b0}}, {2{R_NONE}}
  };

  localparam int W_IC = icode_lsb(W_W, STAT_W);

  logic [3:0]       w_w_icode;
  logic             w_retire;
  logic             w_conflict;
  logic             r_ctrl_err;
  logic [CNT_W-1:0] r_retired;

  pipe_stage_reg #(
    .WIDTH     (WORD_W),
    .BUBBLE_VAL(RESET_PC),
    .RST_VALID (1'b1)
  ) u_f (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall[0]),
    .i_bubble(1'b0),
    .i_d     (f_next),
    .o_q     (F_q),
    .o_valid (valid[0])
  );

  pipe_stage_reg #(
    .WIDTH     (D_W),
    .BUBBLE_VAL(D_BUB)
  ) u_d (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall[1]),
    .i_bubble(bubble[1]),
    .i_d     (d_next),
    .o_q     (D_q),
    .o_valid (valid[1])
  );

  pipe_stage_reg #(
    .WIDTH     (E_W),
    .BUBBLE_VAL(E_BUB)
  ) u_e (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall[2]),
    .i_bubble(bubble[2]),
    .i_d     (e_next),
    .o_q     (E_q),
    .o_valid (valid[2])
  );

  pipe_stage_reg #(
    .WIDTH     (M_W),
    .BUBBLE_VAL(M_BUB)
  ) u_m (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall[3]),
    .i_bubble(bubble[3]),
    .i_d     (m_next),
    .o_q     (M_q),
    .o_valid (valid[3])
  );

  pipe_stage_reg #(
    .WIDTH     (W_W),
    .BUBBLE_VAL(W_BUB)
  ) u_w (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall[4]),
    .i_bubble(bubble[4]),
    .i_d     (w_next),
    .o_q     (W_q),
    .o_valid (valid[4])
  );

  // F has no bubble, so only D..W can conflict.
  assign w_conflict =
    |(stall[4:1] & bubble[4:1]);

  assign w_w_icode = w_next[W_IC +: 4];
  assign w_retire  = ~stall[4] & ~bubble[4]
                   & (w_w_icode != INOP);

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_err <= 1'b0;
    end else if (w_conflict) begin
      r_ctrl_err <= 1'b1;
    end
  end

  // Saturating count of non-NOP W loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire &&
                 (r_retired != '1)) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign ctrl_err = r_ctrl_err;
  assign retired  = r_retired;

endmodule

// File: tb/tb_y86_pipe_regs.sv
// Randomised + directed bench for y86_pipe_regs
// against a stage-level reference model.
module tb_y86_pipe_regs;

  localparam int D_W = 147;
  localparam int E_W = 219;
  localparam int M_W = 144;
  localparam int W_W = 143;
  localparam logic [63:0] RPC = 64'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [63:0]    f_next = '0;
  logic [D_W-1:0] d_next = '0;
  logic [E_W-1:0] e_next = '0;
  logic [M_W-1:0] m_next = '0;
  logic [W_W-1:0] w_next = '0;
  logic [4:0]     stall = '0;
  logic [4:0]     bubble = '0;

  logic [63:0]    F_q;
  logic [D_W-1:0] D_q;
  logic [E_W-1:0] E_q;
  logic [M_W-1:0] M_q;
  logic [W_W-1:0] W_q;
  logic [4:0]     valid;
  logic           ctrl_err;
  logic [31:0]    retired;

  logic [63:0]    F2_q;
  logic [D_W-1:0] D2_q;
  logic [E_W-1:0] E2_q;
  logic [M_W-1:0] M2_q;
  logic [W_W-1:0] W2_q;
  logic [4:0]     valid2;
  logic           err2;
  logic [3:0]     retired4;

  y86_pipe_regs #(
    .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst),
    .f_next(f_next), .d_next(d_next),
    .e_next(e_next), .m_next(m_next),
    .w_next(w_next),
    .stall(stall), .bubble(bubble),
    .F_q(F_q), .D_q(D_q), .E_q(E_q),
    .M_q(M_q), .W_q(W_q),
    .valid(valid), .ctrl_err(ctrl_err),
    .retired(retired)
  );

  y86_pipe_regs #(
    .RESET_PC(RPC),
    .CNT_W   (4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .f_next(f_next), .d_next(d_next),
    .e_next(e_next), .m_next(m_next),
    .w_next(w_next),
    .stall(stall), .bubble(bubble),
    .F_q(F2_q), .D_q(D2_q), .E_q(E2_q),
    .M_q(M2_q), .W_q(W2_q),
    .valid(valid2), .ctrl_err(err2),
    .retired(retired4)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] ms [5];
  logic [255:0] bub [5];
  logic [4:0]   mv;
  logic         merr;
  logic [31:0]  mret;
  logic [3:0]   mret4;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++)
      v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [4:0] rmask();
    logic [4:0] m;
    for (int k = 0; k < 5; k++)
      m[k] = ($urandom_range(0, 5) == 0);
    return m;
  endfunction

  task automatic rnd_inputs(input bit nop_w);
    logic [255:0] t;
    t = rnd256(); f_next = t[63:0];
    t = rnd256(); d_next = t[D_W-1:0];
    t = rnd256(); e_next = t[E_W-1:0];
    t = rnd256(); m_next = t[M_W-1:0];
    t = rnd256(); w_next = t[W_W-1:0];
    if (nop_w) w_next[139:136] = 4'h1;
    else if (w_next[139:136] == 4'h1)
      w_next[139:136] = 4'h6;
  endtask

  // One clock edge as the stage rules describe it.
  task automatic model_edge();
    logic [255:0] nx [5];
    nx[0] = 256'(f_next);
    nx[1] = 256'(d_next);
    nx[2] = 256'(e_next);
    nx[3] = 256'(m_next);
    nx[4] = 256'(w_next);
    if (rst) begin
      ms[0] = 256'(RPC);
      for (int i = 1; i < 5; i++) ms[i] = bub[i];
      mv = 5'b00001;
      merr = 1'b0;
      mret = '0;
      mret4 = '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (stall[i]) begin
          if (i > 0 && bubble[i]) merr = 1'b1;
        end else if (i > 0 && bubble[i]) begin
          ms[i] = bub[i];
          mv[i] = 1'b0;
        end else begin
          ms[i] = nx[i];
          mv[i] = 1'b1;
        end
      end
      if (!stall[4] && !bubble[4] &&
          w_next[139:136] != 4'h1) begin
        if (mret != 32'hFFFF_FFFF) mret = mret + 1;
        if (mret4 != 4'hF) mret4 = mret4 + 1;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h",
             tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("F_q", 256'(F_q), ms[0]);
    chk("D_q", 256'(D_q), ms[1]);
    chk("E_q", 256'(E_q), ms[2]);
    chk("M_q", 256'(M_q), ms[3]);
    chk("W_q", 256'(W_q), ms[4]);
    chk("valid", 256'(valid), 256'(mv));
    chk("ctrl_err", 256'(ctrl_err), 256'(merr));
    chk("retired", 256'(retired), 256'(mret));
    chk("retired4", 256'(retired4), 256'(mret4));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [255:0] sv_f, sv_d, sv_m, exp_d;

  initial begin
    bub[0] = '0;
    bub[1] = 256'({3'd1, 4'h1, 4'h0, 4'hF,
                   4'hF, 128'd0});
    bub[2] = 256'({3'd1, 4'h1, 4'h0, 192'd0,
                   4'hF, 4'hF, 4'hF, 4'hF});
    bub[3] = 256'({3'd1, 4'h1, 1'b0, 128'd0,
                   4'hF, 4'hF});
    bub[4] = 256'({3'd1, 4'h1, 128'd0,
                   4'hF, 4'hF});

    // Reset for two cycles.
    rst = 1'b1; rnd_inputs(1'b0);
    stall = 5'b11111; bubble = 5'b11110;
    step();
    step();
    chk("rst_F", 256'(F_q), 256'(64'h100));
    chk("rst_D_icode", 256'(D_q[143:140]), 256'(4'h1));
    chk("rst_E_dstE", 256'(E_q[15:12]), 256'(4'hF));
    chk("rst_valid", 256'(valid), 256'(5'b00001));
    chk("rst_retired", 256'(retired), 256'(0));

    // Normal flow through D.
    rst = 1'b0; stall = '0; bubble = '0;
    rnd_inputs(1'b0);
    d_next[143:140] = 4'h6;
    d_next[127:64] = 64'h2A;
    exp_d = 256'(d_next);
    step();
    chk("flow_D", 256'(D_q), exp_d);
    chk("flow_v1", 256'(valid[1]), 256'(1'b1));

    // Load-use: stall F+D, bubble E.
    sv_f = ms[0]; sv_d = ms[1];
    rnd_inputs(1'b0);
    stall = 5'b00011; bubble = 5'b00100;
    step();
    chk("lu_F", 256'(F_q), sv_f);
    chk("lu_D", 256'(D_q), sv_d);
    chk("lu_E", 256'(E_q), bub[2]);
    chk("lu_v2", 256'(valid[2]), 256'(1'b0));

    // Conflict on M: hold and set sticky flag.
    sv_m = ms[3];
    rnd_inputs(1'b0);
    stall = 5'b01000; bubble = 5'b01000;
    step();
    chk("cf_M", 256'(M_q), sv_m);
    chk("cf_err", 256'(ctrl_err), 256'(1'b1));
    stall = '0; bubble = '0;
    for (int k = 0; k < 4; k++) begin
      rnd_inputs(1'b0);
      step();
    end
    chk("cf_sticky", 256'(ctrl_err), 256'(1'b1));
    rst = 1'b1; step();
    chk("cf_clear", 256'(ctrl_err), 256'(1'b0));
    rst = 1'b0;

    // 10 W loads (3 NOP) plus 2 W stalls.
    for (int k = 0; k < 12; k++) begin
      rnd_inputs(k == 1 || k == 5 || k == 9);
      stall = (k == 3 || k == 7) ? 5'b10000 : 5'b0;
      bubble = '0;
      step();
    end
    chk("ret_7", 256'(retired), 256'(7));

    // Push the 4-bit counter past saturation.
    stall = '0;
    for (int k = 0; k < 12; k++) begin
      rnd_inputs(1'b0);
      step();
    end
    chk("ret_sat", 256'(retired4), 256'(4'hF));
    chk("ret_19", 256'(retired), 256'(19));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = rmask();
      bubble = rmask();
      rnd_inputs($urandom_range(0, 3) == 0);
      step();
    end

    // Mid-run reset under a full stall.
    rst = 1'b0; stall = '0; bubble = '0;
    rnd_inputs(1'b0); step();
    rst = 1'b1; stall = 5'b11111;
    bubble = 5'b01010;
    rnd_inputs(1'b0); step();
    chk("mr_F", 256'(F_q), 256'(64'h100));
    chk("mr_W", 256'(W_q), bub[4]);
    chk("mr_valid", 256'(valid), 256'(5'b00001));
    chk("mr_ret", 256'(retired), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
